// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit shared types
// op/state encodings, exception codes, helpers
package mem_access_unit_pkg;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LBU  = 4'd2,
    MEM_LH   = 4'd3,
    MEM_LHU  = 4'd4,
    MEM_LW   = 4'd5,
    MEM_SB   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SW   = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_WAIT   = 2'd2,
    S_CANCEL = 2'd3
  } mau_state_e;

  localparam logic [7:0] EXC_ADEL = 8'h04;
  localparam logic [7:0] EXC_ADES = 8'h05;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  function automatic logic is_store(
    input logic [3:0] op
  );
    return (op == MEM_SB) ||
           (op == MEM_SH) ||
           (op == MEM_SW);
  endfunction

  function automatic logic [1:0] op_size(
    input logic [3:0] op
  );
    logic [1:0] s;
    s = SZ_BYTE;
    if ((op == MEM_LH) || (op == MEM_LHU) ||
        (op == MEM_SH))
      s = SZ_HALF;
    if ((op == MEM_LW) || (op == MEM_SW))
      s = SZ_WORD;
    return s;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Load data lane select and extension
// non-load ops yield zero
module load_align
  import mem_access_unit_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [1:0]  a_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] res_o
);

  logic [7:0]  byte_w;
  logic [15:0] half_w;

  assign byte_w = rdata_i[{a_i, 3'b000} +: 8];
  assign half_w = a_i[1] ? rdata_i[31:16]
                         : rdata_i[15:0];

  // extend the selected lane by op
  always_comb begin
    res_o = '0;
    unique case (1'b1)
      (op_i == MEM_LB):
        res_o = {{24{byte_w[7]}}, byte_w};
      (op_i == MEM_LBU):
        res_o = {24'h0, byte_w};
      (op_i == MEM_LH):
        res_o = {{16{half_w[15]}}, half_w};
      (op_i == MEM_LHU):
        res_o = {16'h0, half_w};
      (op_i == MEM_LW):
        res_o = rdata_i;
      default:
        res_o = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-access stage: one bus op per instr
// faulting instrs bypass the bus entirely
module mem_access_unit
  import mem_access_unit_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic        in_exc,
  input  logic [7:0]  in_exccode,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  output logic [3:0]  data_wstrb,
  input  logic        data_addr_ok,
  input  logic [31:0] data_rdata,
  input  logic        data_data_ok,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_rdata,
  output logic        out_exc,
  output logic [7:0]  out_exccode,
  output logic [31:0] out_badvaddr
);

  mau_state_e  state_q, state_d;
  logic [3:0]  op_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        exc_q;
  logic [7:0]  code_q;

  logic        ov_q, ov_d;
  logic [31:0] ord_q, ord_d;
  logic        oexc_q, oexc_d;
  logic [7:0]  ocode_q, ocode_d;
  logic [31:0] obad_q, obad_d;

  logic        accept;
  logic        bypass;
  logic        in_req;
  logic        wait_done;
  logic [31:0] ld_res;

  assign in_ready = (state_q == S_IDLE) &&
                    (!ov_q || out_ready) &&
                    !flush;
  assign accept = in_valid && in_ready;
  assign bypass = in_exc ||
                  (in_op == MEM_NONE);
  assign in_req = (state_q == S_REQ);
  assign wait_done = (state_q == S_WAIT) &&
                     data_data_ok;

  load_align u_align (
    .op_i    (op_q),
    .a_i     (addr_q[1:0]),
    .rdata_i (data_rdata),
    .res_o   (ld_res)
  );

  // bus request fields, held from latches
  always_comb begin
    data_req   = in_req;
    data_wr    = 1'b0;
    data_size  = SZ_BYTE;
    data_addr  = '0;
    data_wdata = '0;
    data_wstrb = '0;
    if (in_req) begin
      data_wr   = is_store(op_q);
      data_size = op_size(op_q);
      data_addr = addr_q;
      unique case (1'b1)
        (op_q == MEM_SB): begin
          data_wdata = {4{wdata_q[7:0]}};
          data_wstrb = 4'b0001 << addr_q[1:0];
        end
        (op_q == MEM_SH): begin
          data_wdata = {2{wdata_q[15:0]}};
          data_wstrb = 4'b0011 <<
                       {addr_q[1], 1'b0};
        end
        (op_q == MEM_SW): begin
          data_wdata = wdata_q;
          data_wstrb = 4'b1111;
        end
        default: ;
      endcase
    end
  end

  // next state; flush abandons or drains
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (accept && !bypass)
          state_d = S_REQ;
      S_REQ:
        if (data_addr_ok)
          state_d = flush ? S_CANCEL : S_WAIT;
        else if (flush)
          state_d = S_IDLE;
      S_WAIT:
        if (data_data_ok)
          state_d = S_IDLE;
        else if (flush)
          state_d = S_CANCEL;
      S_CANCEL:
        if (data_data_ok)
          state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
  end

  // result register; flush beats capture
  always_comb begin
    ov_d    = ov_q;
    ord_d   = ord_q;
    oexc_d  = oexc_q;
    ocode_d = ocode_q;
    obad_d  = obad_q;
    if (flush) begin
      ov_d = 1'b0;
    end else if (accept && bypass) begin
      ov_d    = 1'b1;
      ord_d   = '0;
      oexc_d  = in_exc;
      ocode_d = in_exccode;
      obad_d  = in_addr;
    end else if (wait_done) begin
      ov_d    = 1'b1;
      ord_d   = ld_res;
      oexc_d  = exc_q;
      ocode_d = code_q;
      obad_d  = addr_q;
    end else if (ov_q && out_ready) begin
      ov_d = 1'b0;
    end
  end

  // state, latched instr, result regs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      exc_q   <= 1'b0;
      code_q  <= '0;
      ov_q    <= 1'b0;
      ord_q   <= '0;
      oexc_q  <= 1'b0;
      ocode_q <= '0;
      obad_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q    <= in_op;
        addr_q  <= in_addr;
        wdata_q <= in_wdata;
        exc_q   <= in_exc;
        code_q  <= in_exccode;
      end
      ov_q    <= ov_d;
      ord_q   <= ord_d;
      oexc_q  <= oexc_d;
      ocode_q <= ocode_d;
      obad_q  <= obad_d;
    end
  end

  assign out_valid    = ov_q;
  assign out_rdata    = ord_q;
  assign out_exc      = oexc_q;
  assign out_exccode  = ocode_q;
  assign out_badvaddr = obad_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// mem_access_unit bench: vectors, corners,
// random traffic vs transaction-level model
module tb_mem_access_unit;

  localparam logic [3:0] OP_NONE = 4'd0;
  localparam logic [3:0] OP_LB   = 4'd1;
  localparam logic [3:0] OP_LBU  = 4'd2;
  localparam logic [3:0] OP_LH   = 4'd3;
  localparam logic [3:0] OP_LHU  = 4'd4;
  localparam logic [3:0] OP_LW   = 4'd5;
  localparam logic [3:0] OP_SB   = 4'd6;
  localparam logic [3:0] OP_SH   = 4'd7;
  localparam logic [3:0] OP_SW   = 4'd8;

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic        in_exc;
  logic [7:0]  in_exccode;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok;
  logic [31:0] data_rdata;
  logic        data_data_ok;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rdata;
  logic        out_exc;
  logic [7:0]  out_exccode;
  logic [31:0] out_badvaddr;

  int checks = 0;
  int errors = 0;

  mem_access_unit dut (
    .clk          (clk),
    .resetn       (resetn),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op        (in_op),
    .in_addr      (in_addr),
    .in_wdata     (in_wdata),
    .in_exc       (in_exc),
    .in_exccode   (in_exccode),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_wstrb   (data_wstrb),
    .data_addr_ok (data_addr_ok),
    .data_rdata   (data_rdata),
    .data_data_ok (data_data_ok),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_rdata    (out_rdata),
    .out_exc      (out_exc),
    .out_exccode  (out_exccode),
    .out_badvaddr (out_badvaddr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] wd_exp;
    logic [31:0] rd_exp;
  } vec_t;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } breq_t;

  typedef struct {
    logic [31:0] rdata;
    logic        exc;
    logic [7:0]  code;
    logic [31:0] bad;
  } res_t;

  vec_t  vecs[10];
  breq_t breq_q[$];
  res_t  res_q[$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    in_valid     = 1'b0;
    flush        = 1'b0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    out_ready    = 1'b1;
    in_exc       = 1'b0;
    in_exccode   = 8'h00;
  endtask

  // word the bus slave returns for an address
  function automatic logic [31:0] memf(
    input logic [31:0] a
  );
    return ((a & 32'hFFFF_FFFC) * 32'h9E37_79B1)
           ^ 32'h8080_8080;
  endfunction

  function automatic logic [31:0] ref_load(
    input logic [3:0] op,
    input logic [31:0] a,
    input logic [31:0] w
  );
    logic [31:0] v;
    int sh;
    v = 0;
    if (op == OP_LB || op == OP_LBU) begin
      sh = 8 * int'(a % 4);
      v = (w >> sh) & 32'hFF;
      if (op == OP_LB && v >= 32'h80)
        v = v | 32'hFFFF_FF00;
    end else if (op == OP_LH || op == OP_LHU) begin
      sh = ((a % 4) >= 2) ? 16 : 0;
      v = (w >> sh) & 32'hFFFF;
      if (op == OP_LH && v >= 32'h8000)
        v = v | 32'hFFFF_0000;
    end else if (op == OP_LW) begin
      v = w;
    end
    return v;
  endfunction

  function automatic breq_t ref_req(
    input logic [3:0] op,
    input logic [31:0] a,
    input logic [31:0] wd
  );
    breq_t r;
    r.wr = (op >= OP_SB);
    r.addr = a;
    r.wstrb = 4'h0;
    r.wdata = 32'h0;
    case (op)
      OP_LB, OP_LBU, OP_SB: r.size = 2'd0;
      OP_LH, OP_LHU, OP_SH: r.size = 2'd1;
      default:              r.size = 2'd2;
    endcase
    if (op == OP_SB) begin
      r.wstrb = 4'(1 << (a % 4));
      r.wdata = (wd & 32'hFF) * 32'h0101_0101;
    end else if (op == OP_SH) begin
      r.wstrb = ((a % 4) >= 2) ? 4'hC : 4'h3;
      r.wdata = (wd & 32'hFFFF) * 32'h0001_0001;
    end else if (op == OP_SW) begin
      r.wstrb = 4'hF;
      r.wdata = wd;
    end
    return r;
  endfunction

  task automatic new_input(input bit run);
    in_valid   = run && ($urandom_range(0, 3) != 0);
    in_op      = 4'($urandom_range(0, 8));
    in_exc     = ($urandom_range(0, 5) == 0);
    in_exccode = 8'($urandom);
    in_addr    = $urandom;
    in_wdata   = $urandom;
    if (!in_exc) begin
      if (in_op == OP_LH || in_op == OP_LHU ||
          in_op == OP_SH)
        in_addr[0] = 1'b0;
      if (in_op == OP_LW || in_op == OP_SW)
        in_addr[1:0] = 2'b00;
    end
  endtask

  initial begin
    breq_t eb;
    res_t  er;
    bit    acc;
    bit    pending;
    logic [31:0] paddr;
    int    c;

    vecs[0] = '{OP_LB,  32'h1003, 32'h0,
                32'h8011_2233, 1'b0, 2'd0, 4'h0,
                32'h0, 32'hFFFF_FF80};
    vecs[1] = '{OP_SH,  32'h2002, 32'h0000_BEEF,
                32'h5555_5555, 1'b1, 2'd1, 4'hC,
                32'hBEEF_BEEF, 32'h0};
    vecs[2] = '{OP_LBU, 32'h1001, 32'h0,
                32'h8011_2233, 1'b0, 2'd0, 4'h0,
                32'h0, 32'h0000_0022};
    vecs[3] = '{OP_LH,  32'h2000, 32'h0,
                32'h1234_F00D, 1'b0, 2'd1, 4'h0,
                32'h0, 32'hFFFF_F00D};
    vecs[4] = '{OP_LHU, 32'h4002, 32'h0,
                32'hABCD_0000, 1'b0, 2'd1, 4'h0,
                32'h0, 32'h0000_ABCD};
    vecs[5] = '{OP_LW,  32'h0010, 32'h0,
                32'hDEAD_BEEF, 1'b0, 2'd2, 4'h0,
                32'h0, 32'hDEAD_BEEF};
    vecs[6] = '{OP_SB,  32'h0005, 32'h1234_56A5,
                32'h0, 1'b1, 2'd0, 4'h2,
                32'hA5A5_A5A5, 32'h0};
    vecs[7] = '{OP_SW,  32'h0008, 32'h1234_5678,
                32'h0, 1'b1, 2'd2, 4'hF,
                32'h1234_5678, 32'h0};
    vecs[8] = '{OP_LB,  32'h0022, 32'h0,
                32'h8011_2233, 1'b0, 2'd0, 4'h0,
                32'h0, 32'h0000_0011};
    vecs[9] = '{OP_SH,  32'h0030, 32'hCAFE_1234,
                32'h0, 1'b1, 2'd1, 4'h3,
                32'h1234_1234, 32'h0};

    resetn     = 1'b0;
    in_op      = OP_NONE;
    in_addr    = 32'h0;
    in_wdata   = 32'h0;
    data_rdata = 32'h0;
    idle_in();
    #12;
    chk("rst data_req", data_req, 0);
    chk("rst out_valid", out_valid, 0);
    chk("rst data_addr", data_addr, 0);
    chk("rst data_wstrb", data_wstrb, 0);
    chk("rst data_wdata", data_wdata, 0);
    chk("rst out_rdata", out_rdata, 0);
    chk("rst out_badvaddr", out_badvaddr, 0);
    chk("rst in_ready", in_ready, 1);
    step();
    resetn = 1'b1;

    // table vectors, single-cycle handshakes
    for (int i = 0; i < 10; i++) begin
      step();
      idle_in();
      in_valid     = 1'b1;
      in_op        = vecs[i].op;
      in_addr      = vecs[i].addr;
      in_wdata     = vecs[i].wdata;
      data_addr_ok = 1'b1;
      #1;
      chk($sformatf("v%0d in_ready", i),
          in_ready, 1);
      step();
      in_valid = 1'b0;
      #1;
      chk($sformatf("v%0d req", i), data_req, 1);
      chk($sformatf("v%0d wr", i),
          data_wr, vecs[i].wr);
      chk($sformatf("v%0d size", i),
          data_size, vecs[i].size);
      chk($sformatf("v%0d addr", i),
          data_addr, vecs[i].addr);
      chk($sformatf("v%0d wstrb", i),
          data_wstrb, vecs[i].wstrb);
      if (vecs[i].wr)
        chk($sformatf("v%0d wdata", i),
            data_wdata, vecs[i].wd_exp);
      step();
      data_addr_ok = 1'b0;
      data_data_ok = 1'b1;
      data_rdata   = vecs[i].rdata;
      #1;
      chk($sformatf("v%0d req low", i),
          data_req, 0);
      chk($sformatf("v%0d early ov", i),
          out_valid, 0);
      step();
      data_data_ok = 1'b0;
      #1;
      chk($sformatf("v%0d out_valid", i),
          out_valid, 1);
      chk($sformatf("v%0d out_rdata", i),
          out_rdata, vecs[i].rd_exp);
      chk($sformatf("v%0d out_exc", i),
          out_exc, 0);
      chk($sformatf("v%0d badvaddr", i),
          out_badvaddr, vecs[i].addr);
    end

    // exception bypass: no bus activity
    step();
    idle_in();
    in_valid   = 1'b1;
    in_op      = OP_LW;
    in_addr    = 32'h3001;
    in_exc     = 1'b1;
    in_exccode = 8'h04;
    #1;
    chk("exc in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    in_exc   = 1'b0;
    #1;
    chk("exc req", data_req, 0);
    chk("exc out_valid", out_valid, 1);
    chk("exc out_exc", out_exc, 1);
    chk("exc code", out_exccode, 8'h04);
    chk("exc badvaddr", out_badvaddr, 32'h3001);
    chk("exc rdata", out_rdata, 0);
    step();
    #1;
    chk("exc req after", data_req, 0);
    chk("exc ov after", out_valid, 0);

    // LHU with addr_ok stalled three cycles
    step();
    idle_in();
    in_valid = 1'b1;
    in_op    = OP_LHU;
    in_addr  = 32'h4002;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("stall%0d req", k),
          data_req, 1);
      chk($sformatf("stall%0d addr", k),
          data_addr, 32'h4002);
      chk($sformatf("stall%0d size", k),
          data_size, 1);
      chk($sformatf("stall%0d wr", k),
          data_wr, 0);
      chk($sformatf("stall%0d ready", k),
          in_ready, 0);
      step();
    end
    data_addr_ok = 1'b1;
    #1;
    chk("stall req final", data_req, 1);
    step();
    data_addr_ok = 1'b0;
    data_data_ok = 1'b1;
    data_rdata   = 32'hABCD_0000;
    step();
    data_data_ok = 1'b0;
    #1;
    chk("stall out_valid", out_valid, 1);
    chk("stall out_rdata", out_rdata,
        32'h0000_ABCD);

    // flush in WAIT, data_ok two cycles later
    step();
    idle_in();
    in_valid     = 1'b1;
    in_op        = OP_LW;
    in_addr      = 32'h0040;
    data_addr_ok = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    data_addr_ok = 1'b0;
    flush        = 1'b1;
    #1;
    chk("fw ready in flush", in_ready, 0);
    step();
    flush = 1'b0;
    #1;
    chk("fw ready cancel", in_ready, 0);
    chk("fw ov cancel", out_valid, 0);
    step();
    data_data_ok = 1'b1;
    data_rdata   = 32'h1111_2222;
    #1;
    chk("fw ready data_ok", in_ready, 0);
    step();
    data_data_ok = 1'b0;
    #1;
    chk("fw ready after", in_ready, 1);
    chk("fw no out_valid", out_valid, 0);

    // flush in REQ without addr_ok drops it
    step();
    idle_in();
    in_valid = 1'b1;
    in_op    = OP_SW;
    in_addr  = 32'h0080;
    step();
    in_valid = 1'b0;
    flush    = 1'b1;
    #1;
    chk("fr req", data_req, 1);
    chk("fr ready", in_ready, 0);
    step();
    flush = 1'b0;
    #1;
    chk("fr req dropped", data_req, 0);
    chk("fr ready back", in_ready, 1);
    chk("fr no ov", out_valid, 0);

    // back-pressure holds result, then flush
    step();
    idle_in();
    out_ready  = 1'b0;
    in_valid   = 1'b1;
    in_op      = OP_LW;
    in_addr    = 32'h0100;
    in_exc     = 1'b1;
    in_exccode = 8'h05;
    step();
    in_addr    = 32'h0200;
    in_exccode = 8'h04;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("bp%0d ov", k), out_valid, 1);
      chk($sformatf("bp%0d bad", k),
          out_badvaddr, 32'h0100);
      chk($sformatf("bp%0d code", k),
          out_exccode, 8'h05);
      chk($sformatf("bp%0d ready", k),
          in_ready, 0);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("bp ready rises", in_ready, 1);
    step();
    in_valid  = 1'b0;
    in_exc    = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("bp next ov", out_valid, 1);
    chk("bp next bad", out_badvaddr, 32'h0200);
    chk("bp next code", out_exccode, 8'h04);
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    chk("bp flush clears", out_valid, 0);

    // async reset mid-request
    step();
    idle_in();
    in_valid = 1'b1;
    in_op    = OP_LW;
    in_addr  = 32'h0300;
    step();
    in_valid = 1'b0;
    #1;
    chk("rm req before", data_req, 1);
    resetn = 1'b0;
    #1;
    chk("rm req cleared", data_req, 0);
    chk("rm addr cleared", data_addr, 0);
    chk("rm ready", in_ready, 1);
    step();
    resetn = 1'b1;

    // randomized traffic against the model
    idle_in();
    pending = 1'b0;
    paddr   = 32'h0;
    new_input(1'b1);
    c = 0;
    while (c < 3600) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      if (acc) begin
        er.exc  = in_exc;
        er.code = in_exccode;
        er.bad  = in_addr;
        er.rdata = 32'h0;
        if (!in_exc && in_op != OP_NONE) begin
          breq_q.push_back(
            ref_req(in_op, in_addr, in_wdata));
          er.rdata = ref_load(in_op, in_addr,
                              memf(in_addr));
        end
        res_q.push_back(er);
      end
      if (data_data_ok)
        pending = 1'b0;
      if (data_req && data_addr_ok) begin
        chk("rnd req expected",
            breq_q.size() != 0, 1);
        if (breq_q.size() != 0) begin
          eb = breq_q.pop_front();
          chk("rnd wr", data_wr, eb.wr);
          chk("rnd size", data_size, eb.size);
          chk("rnd addr", data_addr, eb.addr);
          chk("rnd wstrb", data_wstrb, eb.wstrb);
          if (eb.wr)
            chk("rnd wdata", data_wdata, eb.wdata);
        end
        pending = 1'b1;
        paddr   = data_addr;
      end
      if (out_valid && out_ready) begin
        chk("rnd result expected",
            res_q.size() != 0, 1);
        if (res_q.size() != 0) begin
          er = res_q.pop_front();
          chk("rnd out_rdata", out_rdata, er.rdata);
          chk("rnd out_exc", out_exc, er.exc);
          chk("rnd out_code", out_exccode, er.code);
          chk("rnd out_bad", out_badvaddr, er.bad);
        end
      end
      if (c >= 3000 && !in_valid &&
          res_q.size() == 0 &&
          breq_q.size() == 0 && !pending)
        break;
      step();
      if (acc || !in_valid)
        new_input(c < 3000);
      data_addr_ok = ($urandom_range(0, 1) == 1);
      data_data_ok = pending &&
                     ($urandom_range(0, 2) != 0);
      data_rdata   = data_data_ok ? memf(paddr)
                                  : $urandom;
      out_ready    = ($urandom_range(0, 3) != 0);
      c++;
    end
    chk("rnd results drained", res_q.size(), 0);
    chk("rnd reqs drained", breq_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
